// File: rtl/muntjac_fetch_queue.sv
// Fetch-to-backend instruction FIFO of DEPTH entries, flushed on a backend redirect.
// Optional zero-latency pass-through when empty: define MUNTJAC_FETCH_QUEUE_BYPASS_EN.
module muntjac_fetch_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 128,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_instr_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_instr_o,
    output logic [CNT_W-1:0]  count_o
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic              empty, ptr_empty, ptr_full;
    logic              push, pop, bypass, store, pop_mem;

    assign wr_idx    = wr_ptr_q[IDX_W-1:0];
    assign rd_idx    = rd_ptr_q[IDX_W-1:0];
    assign empty     = (count_q == '0);
    assign ptr_empty = (wr_ptr_q == rd_ptr_q);
    assign ptr_full  = (wr_idx == rd_idx) && (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]);

    // Readiness looks only at registered occupancy, so a full queue stays
    // not-ready even in a cycle where the backend pops.
    assign in_ready_o = (count_q < FULL_CNT);
    assign count_o    = count_q;

`ifdef MUNTJAC_FETCH_QUEUE_BYPASS_EN
    assign out_valid_o = (!empty || in_valid_i) && !flush_i;
    assign out_instr_o = empty ? in_instr_i : mem_q[rd_idx];
    assign bypass      = empty && in_valid_i && !flush_i && out_ready_i;
`else
    assign out_valid_o = !empty && !flush_i;
    assign out_instr_o = mem_q[rd_idx];
    assign bypass      = 1'b0;
`endif

    assign push    = in_valid_i && in_ready_o && !flush_i;
    assign pop     = out_valid_o && out_ready_i;
    // A bypassed instruction is consumed straight from the input, never stored.
    assign store   = push && !bypass;
    assign pop_mem = pop && !bypass;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (store)   wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_mem) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (store && !pop_mem)      count_d = count_q + CNT_W'(1);
            else if (!store && pop_mem) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (store) mem_q[wr_idx] <= in_instr_i;
    end

    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && count_q == FULL_CNT));
    a_count_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= FULL_CNT);
    a_ptr_agree: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (empty == ptr_empty) && ((count_q == FULL_CNT) == ptr_full));
    a_head_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (out_valid_o && !out_ready_i && !flush_i) |=> $stable(out_instr_o));

endmodule

// File: tb/tb_muntjac_fetch_queue.sv
// Directed bench for muntjac_fetch_queue: stimulus pushes expected payloads into a
// scoreboard queue, a negedge monitor checks every handshake against it.
module tb_muntjac_fetch_queue;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              flush_i = 1'b0;
    logic              in_valid_i = 1'b0;
    logic              in_ready_o;
    logic [DATA_W-1:0] in_instr_i = '0;
    logic              out_valid_o;
    logic              out_ready_i = 1'b0;
    logic [DATA_W-1:0] out_instr_o;
    logic [CNT_W-1:0]  count_o;

    int n_checks = 0;
    int n_pass   = 0;
    logic [DATA_W-1:0] exp_q [$];

    muntjac_fetch_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_instr_i  (in_instr_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_instr_o (out_instr_o),
        .count_o     (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
            $display("check %-22s got %0h expected %0h ok", name, act, exp);
        end else begin
            $display("FAIL %-22s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: every handshake must match the next expected payload.
    always @(negedge clk_i) begin
        if (rst_ni && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", out_instr_o, 'x);
            end else begin
                check("pop_payload", out_instr_o, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk_i);
        #2;
        check("reset_count", count_o, 0);
        check("reset_in_ready", in_ready_o, 1);
        check("reset_out_valid", out_valid_o, 0);
        step();
        rst_ni = 1'b1;

        // Fill to DEPTH with backend stalled, then drain in order
        for (int i = 0; i < 4; i++) begin
            in_valid_i = 1'b1;
            in_instr_i = DATA_W'(8'hA0 + i);
            exp_q.push_back(DATA_W'(8'hA0 + i));
            step();
        end
        in_valid_i = 1'b0;
        check("fill_count", count_o, 4);
        check("fill_in_ready", in_ready_o, 0);
        out_ready_i = 1'b1;
        repeat (4) step();
        out_ready_i = 1'b0;
        check("drain_count", count_o, 0);

        // Full queue: pop and push offered together, only the pop happens
        for (int i = 0; i < 4; i++) begin
            in_valid_i = 1'b1;
            in_instr_i = DATA_W'(8'hA0 + i);
            exp_q.push_back(DATA_W'(8'hA0 + i));
            step();
        end
        in_valid_i  = 1'b1;
        in_instr_i  = DATA_W'(8'hEE);
        out_ready_i = 1'b1;
        #1;
        check("full_pop_in_ready", in_ready_o, 0);
        step();
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        check("after_full_pop_ready", in_ready_o, 1);
        check("after_full_pop_count", count_o, 3);
        out_ready_i = 1'b1;
        repeat (3) step();
        out_ready_i = 1'b0;
        check("drain2_count", count_o, 0);

        // Steady stream at occupancy 1
        in_valid_i = 1'b1;
        in_instr_i = DATA_W'(16'h100);
        exp_q.push_back(DATA_W'(16'h100));
        step();
        check("stream_start_count", count_o, 1);
        out_ready_i = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            in_instr_i = DATA_W'(16'h100 + i);
            exp_q.push_back(DATA_W'(16'h100 + i));
            step();
            check("stream_count", count_o, 1);
        end
        in_valid_i = 1'b0;
        step();
        out_ready_i = 1'b0;
        check("stream_end_count", count_o, 0);

        // Flush at count 3 with a simultaneous push; nothing may emerge
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'b1;
            in_instr_i = DATA_W'(8'hB0 + i);
            step();
        end
        check("preflush_count", count_o, 3);
        flush_i     = 1'b1;
        in_valid_i  = 1'b1;
        in_instr_i  = DATA_W'(8'hBB);
        out_ready_i = 1'b1;
        #1;
        check("flush_out_valid", out_valid_o, 0);
        step();
        in_valid_i = 1'b0;
        check("flush_count", count_o, 0);
        check("flush_in_ready", in_ready_o, 1);
        step();
        check("flush2_in_ready", in_ready_o, 1);
        flush_i = 1'b0;
        #1;
        check("postflush_out_valid", out_valid_o, 0);
        step();
        out_ready_i = 1'b0;

        // Asynchronous reset mid-stream at count 2
        for (int i = 0; i < 2; i++) begin
            in_valid_i = 1'b1;
            in_instr_i = DATA_W'(8'hC8 + i);
            step();
        end
        in_valid_i = 1'b0;
        check("prereset_count", count_o, 2);
        rst_ni = 1'b0;
        #1;
        check("midreset_out_valid", out_valid_o, 0);
        check("midreset_count", count_o, 0);
        check("midreset_in_ready", in_ready_o, 1);
        step();
        rst_ni = 1'b1;
        in_valid_i = 1'b1;
        in_instr_i = DATA_W'(8'hC0);
        exp_q.push_back(DATA_W'(8'hC0));
        step();
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        check("postreset_count", count_o, 0);

        // Push into empty queue with backend ready
        in_valid_i  = 1'b1;
        in_instr_i  = DATA_W'(8'hD0);
        out_ready_i = 1'b1;
        exp_q.push_back(DATA_W'(8'hD0));
        #1;
`ifdef MUNTJAC_FETCH_QUEUE_BYPASS_EN
        check("bypass_out_valid", out_valid_o, 1);
        check("bypass_out_instr", out_instr_o, DATA_W'(8'hD0));
        step();
        in_valid_i = 1'b0;
        check("bypass_count", count_o, 0);
        #1;
        check("bypass_after_valid", out_valid_o, 0);
`else
        check("nobypass_out_valid", out_valid_o, 0);
        step();
        in_valid_i = 1'b0;
        check("nobypass_count", count_o, 1);
        #1;
        check("nobypass_late_valid", out_valid_o, 1);
        check("nobypass_late_instr", out_instr_o, DATA_W'(8'hD0));
        step();
        check("nobypass_end_count", count_o, 0);
`endif
        out_ready_i = 1'b0;
        step();
        check("scoreboard_empty", DATA_W'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/muntjac_fetch_queue.md
Name: muntjac_fetch_queue

Overview:
Parametrised instruction queue between the instruction fetcher and the backend, generalising today's direct single-entry fetch_valid/fetch_ready coupling to DEPTH entries. Absorbs fetch bursts and backend stalls. The whole queue is flushed when the backend issues a PC redirect. Payload is the packed fetched-instruction record (instr, pc, exception/branch info), carried opaquely.

Parameters:
- DEPTH, 4, number of entries; power of two, ≥ 2.
- DATA_W, 128, payload width in bits; equals the packed fetched_instr_t width at instantiation.
- CNT_W, $clog2(DEPTH+1), width of the occupancy output (derived; not overridden).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  redirect from backend; drops all contents
- in_valid_i  in  1  fetcher has an instruction
- in_ready_o  out  1  queue accepts an instruction this cycle
- in_instr_i  in  DATA_W  fetched instruction payload
- out_valid_o  out  1  instruction available to the backend
- out_ready_i  in  1  backend consumes this cycle
- out_instr_o  out  DATA_W  head payload
- count_o  out  CNT_W  current occupancy, 0..DEPTH

Behaviour:
- Storage: DEPTH×DATA_W register array. Write and read pointers are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - Empty: pointers equal.
  - Full: index bits equal and wrap bits differ.
  - Pointers wrap naturally modulo 2·DEPTH.
- Push: in_valid_i && in_ready_o && !flush_i. Pop: out_valid_o && out_ready_i.
- in_ready_o = (count < DEPTH).
  - Depends on registered state only; no combinational path from out_ready_i.
  - Full with a simultaneous pop: in_ready_o stays 0 that cycle.
- out_valid_o = (count != 0) && !flush_i. out_instr_o = mem[rd_ptr]. Output is registered-storage driven; minimum push-to-pop latency is 1 cycle.
- Simultaneous push and pop when 1 ≤ count < DEPTH: count is unchanged and both pointers advance.
- Empty with push: the entry is visible next cycle.
- Ordering: strict FIFO. Payload is never modified.
- flush_i high:
  - Any same-cycle push is discarded.
  - No pop occurs; out_valid_o is forced to 0.
  - Next cycle: both pointers equal wr_ptr's reset value (0), count = 0.
  - Flush has priority over push and pop.
- Flush on consecutive cycles: the queue stays empty and in_ready_o stays 1.
- count_o: registered; incremented on push-only, decremented on pop-only, unchanged otherwise.
- Reset (async assert, sync-style deassert by the parent): pointers = 0, count_o = 0, out_valid_o = 0, in_ready_o = 1.
  - Array contents are not reset and are don't-care; out_instr_o is don't-care while out_valid_o = 0.
  - Reset mid-operation discards all entries without a flush.
- Assertions (simulation only):
  - No push when full.
  - count_o ≤ DEPTH.
  - out_instr_o stable while out_valid_o && !out_ready_i && !flush_i.

Optional Feature:
- Macro: MUNTJAC_FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When count = 0 and in_valid_i && !flush_i: out_valid_o = 1 and out_instr_o = in_instr_i combinationally.
  - If out_ready_i is also high, the instruction passes through with zero latency and is not written; count stays 0.
  - If out_ready_i is low, it is written normally.
  - in_ready_o is unchanged (still count < DEPTH).
- Undefined: behaviour as above, minimum 1-cycle latency, no combinational in→out path.

Test Plan:
- Reset, then push payloads 0xA0..0xA3 on consecutive cycles with out_ready_i = 0 (DEPTH = 4) → count_o = 4, in_ready_o = 0. Raise out_ready_i → payloads pop in order 0xA0, 0xA1, 0xA2, 0xA3; count_o reaches 0.
- Hold full queue; assert in_valid_i and out_ready_i together for one cycle → one pop (0xA0), no push that cycle; next cycle in_ready_o = 1, count_o = 3.
- Steady stream: push every cycle with out_ready_i = 1 from count = 1 → count_o stays 1 for 20 cycles; output sequence equals input sequence delayed by 1 entry.
- count = 3, assert flush_i with in_valid_i = 1 (payload 0xBB) → out_valid_o = 0 that cycle; next cycle count_o = 0 and in_ready_o = 1; 0xBB is never observed at the output.
- Deassert rst_ni mid-stream at count = 2 → outputs immediately out_valid_o = 0, count_o = 0, in_ready_o = 1. After release, push 0xC0 → 0xC0 is the first popped value.
- With MUNTJAC_FETCH_QUEUE_BYPASS_EN, empty queue, push 0xD0 with out_ready_i = 1 → out_valid_o = 1 and out_instr_o = 0xD0 in the same cycle, count_o stays 0. Without the macro → 0xD0 appears one cycle later.
